// File: rtl/vga_line_fetch_if.sv
// Read-master bus between the line prefetcher and the SDRAM framebuffer port.
//
// Handshake: a request is transferred on a rising edge where
// mem_read=1 and mem_waitrequest=0. While mem_waitrequest=1 the master keeps
// mem_read and mem_address unchanged. mem_readdatavalid=1 marks one returned
// word on mem_readdata; returns arrive in request order, with no back-pressure.
interface vga_line_fetch_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;

    modport master (
        output mem_address,
        output mem_read,
        input  mem_waitrequest,
        input  mem_readdata,
        input  mem_readdatavalid
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        output mem_waitrequest,
        output mem_readdata,
        output mem_readdatavalid
    );
endinterface

// File: rtl/vga_line_fetch.sv
// Double-buffered VGA line prefetcher: the front bank feeds the pixel stage
// while the back bank is filled with the next line by a pipelined read master.
// disp_x is used as a bank index directly, so H_WORDS must not exceed 1024.
module vga_line_fetch #(
    parameter int          H_WORDS   = 640,
    parameter int          MAX_PEND  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock_50,
    input  logic        reset_n,
    input  logic        fetch_start,
    input  logic [8:0]  fetch_line,
    input  logic        disp_active,
    input  logic [9:0]  disp_x,
    output logic [31:0] pix_data,
    vga_line_fetch_if.master mem,
    output logic        busy,
    output logic        underrun,
    output logic [1:0]  state_dbg,
    output logic        front_dbg
);
    localparam int              IDX_W    = $clog2(H_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(H_WORDS - 1);
    localparam logic [3:0]      PEND_MAX = 4'(MAX_PEND);
    localparam logic [10:0]     H_LIM    = 11'(H_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             front;
    logic [8:0]       line;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       pend;
    logic             accept;
    logic             ret;
    logic [31:0]      req_addr;

    logic [31:0] bank0 [H_WORDS];
    logic [31:0] bank1 [H_WORDS];

    // A return only counts when something is outstanding; strays after a reset are dropped.
    assign ret      = mem.mem_readdatavalid && (pend != 4'd0);
    assign req_addr = BASE_ADDR + ((32'(line) * 32'(H_WORDS) + 32'(rd_idx)) << 2);

    // Stall at the outstanding limit unless a return frees a slot this same cycle.
    assign mem.mem_read    = (state == ISSUE) && ((pend != PEND_MAX) || ret);
    assign mem.mem_address = (state == ISSUE) ? req_addr : 32'h0;
    assign accept          = mem.mem_read && !mem.mem_waitrequest;

    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign front_dbg = front;

    // State register.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic: issue every word, then wait for the last one to land.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (fetch_start)                 state_next = ISSUE;
            ISSUE: if (accept && rd_idx == LAST_IDX) state_next = DRAIN;
            DRAIN: if (ret && wr_idx == LAST_IDX)    state_next = IDLE;
            default:                                 state_next = IDLE;
        endcase
    end

    // Fetch bookkeeping: bank swap, line latch, request/return counters, underrun flag.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            front    <= 1'b0;
            line     <= 9'd0;
            rd_idx   <= '0;
            wr_idx   <= '0;
            pend     <= 4'd0;
            underrun <= 1'b0;
        end else if (fetch_start && state == IDLE) begin
            front  <= !front;
            line   <= fetch_line;
            rd_idx <= '0;
            wr_idx <= '0;
            pend   <= 4'd0;
        end else begin
            if (fetch_start) underrun <= 1'b1;
            if (accept)      rd_idx   <= rd_idx + IDX_W'(1);
            if (ret)         wr_idx   <= wr_idx + IDX_W'(1);
            pend <= pend + 4'(accept) - 4'(ret);
        end
    end

    // Returned words go into the back bank; storage itself is not reset.
    always_ff @(posedge clock_50) begin
        if (ret) begin
            if (front) bank0[wr_idx] <= mem.mem_readdata;
            else       bank1[wr_idx] <= mem.mem_readdata;
        end
    end

    // Registered pixel read from the front bank, blanked outside the visible line.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            pix_data <= 32'h0;
        end else if (disp_active && ({1'b0, disp_x} < H_LIM)) begin
            pix_data <= front ? bank1[disp_x[IDX_W-1:0]] : bank0[disp_x[IDX_W-1:0]];
        end else begin
            pix_data <= 32'h0;
        end
    end
endmodule
